// File: rtl/debug_uart_tx.sv
// debug_uart_tx: FIFO-fed UART transmitter (in: clk, res, wr_en, wdata; out: full, busy, tx, overflow); define DEBUG_UART_PARITY_EN for an even-parity bit
module debug_uart_tx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic       wr_en,
  input  logic [7:0] wdata,
  output logic       full,
  output logic       busy,
  output logic       tx,
  output logic       overflow
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp, wp_n, rp_n;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          empty, tick, pop, we, idle_n, full_n, busy_n;
`ifdef DEBUG_UART_PARITY_EN
  logic          par;
`endif
  assign empty  = wp == rp;
  assign tick   = cnt == CW'(DIV - 1);
  assign pop    = !empty && (state == IDLE || (state == STOP && tick));
  assign we     = wr_en && (!full || pop);
  assign wp_n   = wp + {{AW{1'b0}}, we};
  assign rp_n   = rp + {{AW{1'b0}}, pop};
  assign full_n = (wp_n[AW] != rp_n[AW]) && (wp_n[AW-1:0] == rp_n[AW-1:0]);
  assign idle_n = empty && (state == IDLE || (state == STOP && tick));
  assign busy_n = !(idle_n && !we);
  always_ff @(posedge clk) begin
    if (!res && we) mem[wp[AW-1:0]] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state    <= IDLE;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      tx       <= 1'b1;
      full     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
`ifdef DEBUG_UART_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      wp       <= wp_n;
      rp       <= rp_n;
      full     <= full_n;
      busy     <= busy_n;
      overflow <= overflow | (wr_en && full && !pop);
      cnt      <= (tick || state == IDLE) ? '0 : cnt + 1'b1;
      if (pop) begin
        sh <= mem[rp[AW-1:0]];
`ifdef DEBUG_UART_PARITY_EN
        par <= ^mem[rp[AW-1:0]];
`endif
      end
      case (state)
        IDLE: if (pop) begin
          state <= START;
          tx    <= 1'b0;
        end
        START: if (tick) begin
          state <= DATA;
          tx    <= sh[0];
        end
        DATA: if (tick) begin
          idx <= idx + 1'b1;
          sh  <= sh >> 1;
          if (idx == 3'd7) begin
`ifdef DEBUG_UART_PARITY_EN
            state <= PARITY;
            tx    <= par;
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else begin
            tx <= sh[1];
          end
        end
        PARITY: if (tick) begin
          state <= STOP;
          tx    <= 1'b1;
        end
        STOP: if (tick) begin
          state <= pop ? START : IDLE;
          tx    <= !pop;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
